// File: rtl/seg_scan_pkg.sv
// Shared constants and FSM encoding for the seg_scan_ctrl multiplexed 7-segment scanner.
package seg_scan_pkg;

    localparam int DEF_N_DIGITS  = 4;
    localparam int DEF_PRESCALE  = 1000;
    localparam int DEF_LT_FRAMES = 2;

    // drv_7seg lights every segment while its lt input is low
    localparam logic LT_ACTIVE = 1'b0;
    localparam logic LT_IDLE   = 1'b1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_LTEST = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_prescaler.sv
// Free-running slot prescaler: counts 0..PRESCALE-1 and flags the last count as the slot tick.
module seg_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == CW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with shadow register, blanking and timed lamp test.
// Build option: define SEG_SCAN_DP_EN to carry the decimal point (bit 7) through the shadow.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS  = DEF_N_DIGITS,
    parameter int PRESCALE  = DEF_PRESCALE,
    parameter int LT_FRAMES = DEF_LT_FRAMES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8*N_DIGITS-1:0] digits,
    input  logic                  load,
    input  logic                  lt_req,
    input  logic                  blank,
    output logic [7:0]            seg,
    output logic                  lt,
    output logic [N_DIGITS-1:0]   an,
    output logic                  busy,
    output logic                  frame_tick
);

    localparam int IW = $clog2(N_DIGITS);
    localparam int FW = $clog2(LT_FRAMES + 1);
`ifdef SEG_SCAN_DP_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif

    logic                slot_tick;
    logic [IW-1:0]       idx_reg;
    logic                frame_tick_reg;
    logic [SW-1:0]       digit_in [N_DIGITS];
    logic [SW-1:0]       shadow_reg [N_DIGITS];
    logic [7:0]          seg_reg, seg_next;
    logic [N_DIGITS-1:0] an_reg, an_next;
    scan_state_t         state_reg, state_next;
    logic [FW-1:0]       frames_reg, frames_next;
    logic                lt_reg, busy_reg;
    logic                unused_digits;

    seg_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (slot_tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign digit_in[gi] = digits[8*gi +: SW];
        end
    endgenerate

    // Without the decimal point option the top bit of each digit is dropped on purpose
    assign unused_digits = ^digits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg        <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= slot_tick && (idx_reg == IW'(N_DIGITS - 1));
            if (slot_tick) begin
                idx_reg <= (idx_reg == IW'(N_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_reg[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_reg[i] <= digit_in[i];
            end
        end
    end

    always_comb begin
        seg_next         = '0;
        seg_next[SW-1:0] = shadow_reg[idx_reg];
        an_next          = blank ? '0 : ({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_reg);
    end

    // Lamp test counts only frame ticks seen while already in LTEST
    always_comb begin
        state_next  = state_reg;
        frames_next = frames_reg;
        case (state_reg)
            ST_RUN: begin
                if (lt_req) begin
                    state_next  = ST_LTEST;
                    frames_next = '0;
                end
            end
            ST_LTEST: begin
                if (frame_tick_reg) begin
                    if (frames_reg == FW'(LT_FRAMES - 1)) begin
                        state_next = ST_RUN;
                    end else begin
                        frames_next = frames_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_RUN;
            frames_reg <= '0;
            seg_reg    <= '0;
            an_reg     <= '0;
            lt_reg     <= LT_IDLE;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            frames_reg <= frames_next;
            seg_reg    <= seg_next;
            an_reg     <= an_next;
            lt_reg     <= (state_next == ST_LTEST) ? LT_ACTIVE : LT_IDLE;
            busy_reg   <= (state_next == ST_LTEST);
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign lt         = lt_reg;
    assign busy       = busy_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against an edge-count based reference model.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int P  = 4;
    localparam int LT = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [8*N-1:0] digits = '0;
    logic           load = 1'b0;
    logic           lt_req = 1'b0;
    logic           blank = 1'b0;
    logic [7:0]     seg;
    logic           lt;
    logic [N-1:0]   an;
    logic           busy;
    logic           frame_tick;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .N_DIGITS  (N),
        .PRESCALE  (P),
        .LT_FRAMES (LT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .load       (load),
        .lt_req     (lt_req),
        .blank      (blank),
        .seg        (seg),
        .lt         (lt),
        .an         (an),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: k counts clock edges since reset release
    int           k;
    logic [7:0]   m_shadow [N];
    bit           m_lt_active;
    int           m_frames;
    bit           m_ft;
    logic [7:0]   e_seg;
    logic [N-1:0] e_an;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t, edge %0d)", tag, got, exp, $time, k);
        end
    endtask

    function automatic logic [7:0] dp_mask(input logic [7:0] v);
`ifdef SEG_SCAN_DP_EN
        return v;
`else
        return v & 8'h7f;
`endif
    endfunction

    task automatic model_reset();
        k           = 0;
        m_lt_active = 1'b0;
        m_frames    = 0;
        m_ft        = 1'b0;
        e_seg       = '0;
        e_an        = '0;
        for (int i = 0; i < N; i++) m_shadow[i] = '0;
    endtask

    // Applied at each rising edge with the inputs the DUT samples on that edge
    task automatic model_edge();
        int cur_idx;
        cur_idx = (k / P) % N;
        e_seg   = m_shadow[cur_idx];
        e_an    = blank ? '0 : (N'(1) << cur_idx);
        if (!m_lt_active) begin
            if (lt_req) begin
                m_lt_active = 1'b1;
                m_frames    = 0;
            end
        end else if (m_ft) begin
            if (m_frames + 1 == LT) m_lt_active = 1'b0;
            else                    m_frames++;
        end
        if (load) begin
            for (int i = 0; i < N; i++) m_shadow[i] = dp_mask(digits[8*i +: 8]);
        end
        k++;
        m_ft = (k % (P * N) == 0);
    endtask

    task automatic check_outputs();
        check_val("seg", seg, e_seg);
        check_val("an", an, e_an);
        check_val("lt", lt, !m_lt_active);
        check_val("busy", busy, m_lt_active);
        check_val("frame_tick", frame_tick, m_ft);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        bit found;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();

        // Release reset, load 03020100, watch plain scanning
        rst_n  = 1'b1;
        digits = 32'h0302_0100;
        load   = 1'b1;
        cycle();
        load   = 1'b0;
        repeat (40) cycle();

        // Single-cycle lamp test request
        lt_req = 1'b1;
        cycle();
        lt_req = 1'b0;
        repeat (60) cycle();

        // Request on the edge where frame_tick is high, then a repeat mid-test
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_ft) found = 1'b1;
            else      cycle();
        end
        check_val("ft_wait", found, 1'b1);
        lt_req = 1'b1;
        cycle();
        lt_req = 1'b0;
        repeat (20) cycle();
        lt_req = 1'b1;
        cycle();
        lt_req = 1'b0;
        repeat (50) cycle();

        // Blank window mid-frame
        repeat (3) cycle();
        blank = 1'b1;
        repeat (10) cycle();
        blank = 1'b0;
        repeat (10) cycle();

        // Random traffic
        repeat (600) begin
            digits = $urandom;
            load   = ($urandom_range(0, 7) == 0);
            lt_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) blank = ~blank;
            cycle();
        end
        load   = 1'b0;
        lt_req = 1'b0;
        blank  = 1'b0;

        // Asynchronous reset in the middle of a lamp test
        lt_req = 1'b1;
        cycle();
        lt_req = 1'b0;
        repeat (10) cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n  = 1'b1;
        digits = 32'h0302_0100;
        load   = 1'b1;
        cycle();
        load   = 1'b0;
        repeat (20) cycle();

        // Decimal point handling
        digits = 32'h8080_8080;
        load   = 1'b1;
        cycle();
        load   = 1'b0;
        repeat (20) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 Parameter PRESCALE, default 1000, clk cycles per digit slot (minimum 2).
REQ-003 Parameter LT_FRAMES, default 2, number of full scan frames per lamp test (minimum 1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 digits  input  8*N_DIGITS  segment patterns; digit k occupies bits [8k+7:8k].
REQ-007 load  input  1  latch digits into the shadow register.
REQ-008 lt_req  input  1  lamp-test request, sampled level.
REQ-009 blank  input  1  forces all digit enables off.
REQ-010 seg  output  8  segment pattern for the drv_7seg inbus.
REQ-011 lt  output  1  drv_7seg lamp-test control; 1 = normal, 0 = all segments lit.
REQ-012 an  output  N_DIGITS  one-hot digit enable, active-high.
REQ-013 busy  output  1  high while a lamp test is in progress.
REQ-014 frame_tick  output  1  one-cycle pulse at the end of each full frame.

Function
REQ-015 Prescaler: counts 0..PRESCALE-1 and wraps; slot tick when count == PRESCALE-1.
REQ-016 Slot tick: digit index idx advances; N_DIGITS-1 wraps to 0.
REQ-017 frame_tick is registered and high for exactly the cycle after the tick that wraps idx to 0.
REQ-018 seg and an are registered: seg = shadow[idx], an = (1 << idx); both update the cycle after idx changes (1-cycle latency).
REQ-019 load = 1 overwrites the shadow on that edge; the new value appears on seg no later than the next slot.
REQ-020 blank = 1 forces an = 0 from the next cycle; seg keeps tracking idx; scanning continues uninterrupted.
REQ-021 FSM states are RUN and LTEST; reset state is RUN.
REQ-022 RUN -> LTEST on the edge where lt_req = 1: the frame counter is cleared, and lt = 0 and busy = 1 from the next cycle.
REQ-023 In LTEST, each frame_tick increments the frame counter; at LT_FRAMES the FSM returns to RUN, and lt = 1 and busy = 0 on the following cycle.
REQ-024 lt_req in LTEST is ignored; a lamp test is never extended or restarted.
REQ-025 A frame_tick coincident with the RUN -> LTEST transition is not counted.
REQ-026 Scanning, load and blank behave identically in LTEST; blank overrides, so an = 0 even in LTEST.
REQ-027 Lamp-test entry and exit do not reset idx or the prescaler.

Reset
REQ-028 Reset values: seg = 0, an = 0, lt = 1, busy = 0, frame_tick = 0; idx, prescaler, frame counter and shadow = 0; FSM = RUN.
REQ-029 Reset asserted mid-lamp-test aborts it immediately (asynchronous); lt = 1.
REQ-030 On the first edge after rst_n deasserts: an = 1 (digit 0), seg = 0.

Configuration
REQ-031 Macro SEG_SCAN_DP_EN defined: seg[7] (decimal point) is taken from the shadow.
REQ-032 Macro SEG_SCAN_DP_EN undefined: seg[7] is forced to 0; the shadow stores only bits [6:0] per digit.

Structure
REQ-033 Shared package (header seg_scan_pkg): FSM state encodings, default PRESCALE/LT_FRAMES/N_DIGITS constants, and the active level of lt.
REQ-034 Submodule seg_prescaler (PRESCALE parameter, outputs the slot tick), instantiated once.
REQ-035 The drv_7seg instance lives outside this block; seg drives its inbus and lt drives its lt.

Verification (N_DIGITS=4, PRESCALE=4, LT_FRAMES=2)
REQ-036 Reset release, digits = 0x03020100 loaded -> an cycles 1,2,4,8 every 4 clk; seg follows 00,01,02,03; frame_tick every 16 clk.
REQ-037 lt_req pulsed one cycle -> lt = 0 and busy = 1 for exactly 2 frame_ticks (~32 clk), then lt = 1; scan order unbroken.
REQ-038 lt_req on the same edge as frame_tick -> that tick is not counted; lt = 0 spans 2 further frame_ticks; a repeated lt_req mid-test has no effect.
REQ-039 blank = 1 for 10 clk mid-frame -> an = 0 over that window; on release, an resumes at the correct one-hot for the current idx.
REQ-040 rst_n low mid-lamp-test -> outputs immediately at reset values; recovery as in REQ-036.
REQ-041 digits = 0x80808080 loaded -> seg = 0x80 with SEG_SCAN_DP_EN, seg = 0x00 without.
